// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU modes, register-address width and the opcode decoder.
package decode_pkg;

  localparam int REG_AW = 2;
  localparam int DATA_W = 8;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_NAND = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_IN   = 4'd11,
    OP_MOV  = 4'd13
  } opcode_e;

  typedef enum logic [2:0] {
    MODE_PASS = 3'd0,
    MODE_ADD  = 3'd1,
    MODE_SUB  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_SHL  = 3'd4,
    MODE_SHR  = 3'd5
  } alu_mode_e;

  typedef struct packed {
    alu_mode_e mode;
    logic      use_a;
    logic      use_b;
    logic      wr;
    logic      illegal;
  } dec_t;

  // Undefined opcodes fall out as a NOP with the illegal bit raised.
  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d.mode    = MODE_PASS;
    d.use_a   = 1'b0;
    d.use_b   = 1'b0;
    d.wr      = 1'b1;
    d.illegal = 1'b0;
    case (op)
      OP_NOP:  d.wr = 1'b0;
      OP_ADD:  begin d.mode = MODE_ADD;  d.use_a = 1'b1; d.use_b = 1'b1; end
      OP_SUB:  begin d.mode = MODE_SUB;  d.use_a = 1'b1; d.use_b = 1'b1; end
      OP_NAND: begin d.mode = MODE_NAND; d.use_a = 1'b1; d.use_b = 1'b1; end
      OP_SHL:  begin d.mode = MODE_SHL;  d.use_a = 1'b1; end
      OP_SHR:  begin d.mode = MODE_SHR;  d.use_a = 1'b1; end
      OP_IN:   ;
      OP_MOV:  d.use_b = 1'b1;
      default: begin d.wr = 1'b0; d.illegal = 1'b1; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 4x8 register file, one write port, two combinational read ports with write-through.
// Writes land at the rising edge; a read of the address being written returns the write data.
module reg_file
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : mem[rd_addr_a];
  assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : mem[rd_addr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register read, hazard check against execute, registered ID/EX operands.
// Build option DECODE_FORWARDING_EN: forward ex_result to hazard sources instead of stalling.
module decode_stage
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       stall,
  input  logic       flush,
  input  logic [7:0] in_port,
  input  logic       wb_en,
  input  logic [1:0] wb_addr,
  input  logic [7:0] wb_data,
  input  logic       ex_wr,
  input  logic [1:0] ex_dest,
  input  logic [7:0] ex_result,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [2:0] alu_mode,
  output logic [1:0] dest,
  output logic       wr_en,
  output logic       valid,
  output logic       illegal_op
);

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  dec_t       dec;
  logic [7:0] rf_a;
  logic [7:0] rf_b;
  logic [7:0] opa;
  logic [7:0] opb;
  logic       haz_a;
  logic       haz_b;
  logic       hazard_stall;
  logic       accept;
  logic [7:0] nx_in1;
  logic [7:0] nx_in2;

  assign op  = instr[7:4];
  assign ra  = instr[3:2];
  assign rb  = instr[1:0];
  assign dec = decode_op(op);

  reg_file u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (ra),
    .rd_data_a (rf_a),
    .rd_addr_b (rb),
    .rd_data_b (rf_b)
  );

  assign haz_a = ex_wr & dec.use_a & (ex_dest == ra);
  assign haz_b = ex_wr & dec.use_b & (ex_dest == rb);

  // Forwarded operands are harmless without forwarding: a hazard then loads a bubble instead.
  assign opa = haz_a ? ex_result : rf_a;
  assign opb = haz_b ? ex_result : rf_b;

`ifdef DECODE_FORWARDING_EN
  assign hazard_stall = 1'b0;
`else
  assign hazard_stall = instr_valid & (haz_a | haz_b);
`endif

  assign instr_ready = !stall && !hazard_stall;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    nx_in1 = '0;
    nx_in2 = '0;
    case (op)
      OP_ADD, OP_SUB, OP_NAND: begin
        nx_in1 = opa;
        nx_in2 = opb;
      end
      OP_SHL, OP_SHR: begin
        nx_in1 = opa;
        nx_in2 = {6'b0, rb};
      end
      OP_MOV:  nx_in2 = opb;
      OP_IN:   nx_in2 = in_port;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1        <= '0;
      in2        <= '0;
      alu_mode   <= '0;
      dest       <= '0;
      wr_en      <= 1'b0;
      valid      <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (accept && dec.illegal) illegal_op <= 1'b1;
      if (flush || (!stall && !accept)) begin
        in1      <= '0;
        in2      <= '0;
        alu_mode <= '0;
        dest     <= '0;
        wr_en    <= 1'b0;
        valid    <= 1'b0;
      end else if (!stall) begin
        in1      <= nx_in1;
        in2      <= nx_in2;
        alu_mode <= dec.mode;
        dest     <= ra;
        wr_en    <= dec.wr;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, hand sequences, randomized run against a model.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       stall;
  logic       flush;
  logic [7:0] in_port;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       ex_wr;
  logic [1:0] ex_dest;
  logic [7:0] ex_result;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [2:0] alu_mode;
  logic [1:0] dest;
  logic       wr_en;
  logic       valid;
  logic       illegal_op;

`ifdef DECODE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .stall(stall), .flush(flush), .in_port(in_port), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_wr(ex_wr), .ex_dest(ex_dest), .ex_result(ex_result), .in1(in1),
    .in2(in2), .alu_mode(alu_mode), .dest(dest), .wr_en(wr_en), .valid(valid),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural registers, expected ID/EX word, sticky illegal flag.
  logic [7:0]  m_r [4];
  logic [22:0] m_out;
  logic        m_ill;

  typedef struct {
    logic [7:0]  instr;
    logic        iv;
    logic        st;
    logic        fl;
    logic        we;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic [7:0]  inp;
    logic        rdy;
    logic [22:0] exp;
  } row_t;

  row_t tbl [16];

  function automatic logic [22:0] o(input logic v, input logic w, input logic [1:0] d,
                                    input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    return {v, w, d, m, a, b};
  endfunction

  function automatic logic [22:0] idex();
    return {valid, wr_en, dest, alu_mode, in1, in2};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_def(input logic [3:0] opc);
    return opc inside {4'd0, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13};
  endfunction

  function automatic logic [7:0] src(input logic [1:0] r);
    if (ex_wr && ex_dest == r) return ex_result;
    if (wb_en && wb_addr == r) return wb_data;
    return m_r[r];
  endfunction

  // Architectural behaviour of one cycle, straight from the instruction table.
  task automatic model_eval(output logic [22:0] nxt, output logic nill, output logic rdy);
    logic [3:0] opc;
    logic [1:0] ra, rb;
    logic       ua, ub, haz;
    logic [2:0] md;
    logic [7:0] i1, i2;
    opc = instr[7:4]; ra = instr[3:2]; rb = instr[1:0];
    ua = 0; ub = 0; md = 0; i1 = 0; i2 = 0;
    case (opc)
      4'd4:  begin ua = 1; ub = 1; md = 1; i1 = src(ra); i2 = src(rb); end
      4'd5:  begin ua = 1; ub = 1; md = 2; i1 = src(ra); i2 = src(rb); end
      4'd8:  begin ua = 1; ub = 1; md = 3; i1 = src(ra); i2 = src(rb); end
      4'd9:  begin ua = 1; md = 4; i1 = src(ra); i2 = 8'(rb); end
      4'd10: begin ua = 1; md = 5; i1 = src(ra); i2 = 8'(rb); end
      4'd11: i2 = in_port;
      4'd13: begin ub = 1; i2 = src(rb); end
      default: ;
    endcase
    haz  = instr_valid && ex_wr && ((ua && ex_dest == ra) || (ub && ex_dest == rb));
    rdy  = !stall && !(haz && !FWD);
    nill = m_ill || (instr_valid && rdy && !is_def(opc));
    if (flush) nxt = '0;
    else if (stall) nxt = m_out;
    else if (instr_valid && rdy) nxt = o(1'b1, opc != 0 && is_def(opc), ra, md, i1, i2);
    else nxt = '0;
  endtask

  task automatic step_model(input string nm);
    logic [22:0] nx;
    logic        ni, r;
    #2;
    model_eval(nx, ni, r);
    check({nm, " ready"}, 32'(instr_ready), 32'(r));
    @(posedge clk); #1;
    if (wb_en) m_r[wb_addr] = wb_data;
    m_out = nx;
    m_ill = ni;
    check({nm, " idex"}, 32'(idex()), 32'(m_out));
    check({nm, " illegal"}, 32'(illegal_op), 32'(m_ill));
  endtask

  task automatic idle();
    instr = 8'h00; instr_valid = 0; stall = 0; flush = 0; in_port = 8'h00;
    wb_en = 0; wb_addr = 0; wb_data = 8'h00; ex_wr = 0; ex_dest = 0; ex_result = 8'h00;
  endtask

  initial begin
    tbl[0]  = '{8'h00, 0, 0, 0, 1, 2'd1, 8'h05, 8'h00, 1, o(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[1]  = '{8'h00, 0, 0, 0, 1, 2'd2, 8'h03, 8'h00, 1, o(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[2]  = '{8'h46, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 1, 1, 1, 8'h05, 8'h03)};
    tbl[3]  = '{8'hD3, 1, 0, 0, 1, 2'd3, 8'h7E, 8'h00, 1, o(1, 1, 0, 0, 8'h00, 8'h7E)};
    tbl[4]  = '{8'h9B, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 1, 2, 4, 8'h03, 8'h03)};
    tbl[5]  = '{8'h46, 1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0, o(1, 1, 2, 4, 8'h03, 8'h03)};
    tbl[6]  = '{8'h46, 1, 1, 0, 0, 2'd0, 8'h00, 8'h00, 0, o(1, 1, 2, 4, 8'h03, 8'h03)};
    tbl[7]  = '{8'h46, 1, 1, 1, 0, 2'd0, 8'h00, 8'h00, 0, o(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[8]  = '{8'hB4, 1, 0, 0, 0, 2'd0, 8'h00, 8'h5A, 1, o(1, 1, 1, 0, 8'h00, 8'h5A)};
    tbl[9]  = '{8'h58, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 1, 2, 2, 8'h03, 8'h00)};
    tbl[10] = '{8'h8E, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 1, 3, 3, 8'h7E, 8'h03)};
    tbl[11] = '{8'hA7, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 1, 1, 5, 8'h05, 8'h03)};
    tbl[12] = '{8'h46, 1, 0, 1, 0, 2'd0, 8'h00, 8'h00, 1, o(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[13] = '{8'h00, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(1, 0, 0, 0, 8'h00, 8'h00)};
    tbl[14] = '{8'h46, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 1, o(0, 0, 0, 0, 8'h00, 8'h00)};
    tbl[15] = '{8'h4D, 1, 0, 0, 1, 2'd3, 8'h11, 8'h00, 1, o(1, 1, 3, 1, 8'h11, 8'h05)};

    // Reset with live-looking inputs: nothing may be captured or written.
    idle();
    rst = 1;
    instr = 8'h46; instr_valid = 1; wb_en = 1; wb_addr = 1; wb_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset idex", 32'(idex()), 32'd0);
    check("reset illegal", 32'(illegal_op), 32'd0);
    idle();
    rst = 0;

    foreach (tbl[i]) begin
      instr = tbl[i].instr; instr_valid = tbl[i].iv; stall = tbl[i].st; flush = tbl[i].fl;
      wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd; in_port = tbl[i].inp;
      #2;
      check($sformatf("row%0d ready", i), 32'(instr_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      check($sformatf("row%0d idex", i), 32'(idex()), 32'(tbl[i].exp));
      check($sformatf("row%0d illegal", i), 32'(illegal_op), 32'd0);
    end
    idle();

    // Hazard on ra against execute: forward or stall-then-reissue. Regs: R1=05 R2=03 R3=11.
    instr = 8'h46; instr_valid = 1; ex_wr = 1; ex_dest = 1; ex_result = 8'hAA;
    #2;
    check("hazard ready", 32'(instr_ready), FWD ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check("hazard idex", 32'(idex()), FWD ? 32'(o(1, 1, 1, 1, 8'hAA, 8'h03)) : 32'd0);
    ex_wr = 0;
    #2;
    check("reissue ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check("reissue idex", 32'(idex()), 32'(o(1, 1, 1, 1, 8'h05, 8'h03)));
    // Shift amount field is not a register source, so matching ex_dest is no hazard.
    instr = 8'h96; ex_wr = 1; ex_dest = 2; ex_result = 8'hCC;
    #2;
    check("shamt nohaz ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check("shamt nohaz idex", 32'(idex()), 32'(o(1, 1, 1, 4, 8'h05, 8'h02)));
    ex_wr = 0;

    // Undefined opcode, sticky flag, then async reset mid-cycle.
    instr = 8'hF0;
    @(posedge clk); #1;
    check("illegal idex", 32'(idex()), 32'(o(1, 0, 0, 0, 8'h00, 8'h00)));
    check("illegal set", 32'(illegal_op), 32'd1);
    instr = 8'h46;
    @(posedge clk); #1;
    check("after illegal idex", 32'(idex()), 32'(o(1, 1, 1, 1, 8'h05, 8'h03)));
    check("illegal sticky", 32'(illegal_op), 32'd1);
    #3 rst = 1;
    #1;
    check("async reset idex", 32'(idex()), 32'd0);
    check("async reset illegal", 32'(illegal_op), 32'd0);
    idle();
    @(posedge clk); #1;
    rst = 0;
    for (int r = 0; r < 4; r++) m_r[r] = 8'h00;
    m_out = '0;
    m_ill = 1'b0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      instr       = 8'($urandom);
      instr_valid = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      if (flush && !is_def(instr[7:4])) instr[7:4] = 4'd4;
      if (n < 300 && !is_def(instr[7:4])) instr[7:4] = 4'd13;
      in_port     = 8'($urandom);
      wb_en       = 1'($urandom);
      wb_addr     = 2'($urandom);
      wb_data     = 8'($urandom);
      ex_wr       = 1'($urandom);
      ex_dest     = 2'($urandom);
      ex_result   = 8'($urandom);
      step_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
